// File: rtl/arm_control_fsm_if.sv
// Control-unit bus: instruction/flag/handshake inputs from the datapath and
// the packed control word plus debug state returned to it.
interface arm_control_fsm_if;
   logic [31:0] IR_In;
   logic        MFC;
   logic [3:0]  Flags;
   logic [32:0] Ctrl;
   logic [3:0]  State;

   modport master (
      output IR_In,
      output MFC,
      output Flags,
      input  Ctrl,
      input  State
   );

   modport slave (
      input  IR_In,
      input  MFC,
      input  Flags,
      output Ctrl,
      output State
   );
endinterface

// File: rtl/arm_control_fsm.sv
// Multi-cycle ARM control unit: fetch, condition check, decode and execute
// sequencing that emits a Moore control word for the datapath.
module arm_control_fsm (
   input  logic              CLK,
   input  logic              CLR,
   arm_control_fsm_if.slave  bus
);

   typedef enum logic [3:0] {
      ST_RST     = 4'd0,
      ST_F_MAR   = 4'd1,
      ST_F_PC    = 4'd2,
      ST_F_WAIT  = 4'd3,
      ST_F_IR    = 4'd4,
      ST_DECODE  = 4'd5,
      ST_DP      = 4'd6,
      ST_BL_LINK = 4'd7,
      ST_BR      = 4'd8,
      ST_M_ADDR  = 4'd9,
      ST_LD_WAIT = 4'd10,
      ST_LD_WB   = 4'd11,
      ST_ST_MDR  = 4'd12,
      ST_ST_WAIT = 4'd13
   } state_t;

   // The named fields fill bits 32..1; bit 0 is an unused spare tied low.
   typedef struct packed {
      logic       mfa;
      logic       rw_ram;
      logic       salu;
      logic [1:0] data_size;
      logic       rf_clr;
      logic       rf_rw;
      logic [1:0] wra;
      logic [1:0] sra;
      logic [1:0] srb;
      logic [1:0] sise;
      logic [1:0] salub;
      logic [3:0] alua;
      logic       ssab;
      logic       ssop;
      logic       sma;
      logic       sta;
      logic       mar_en;
      logic       sr_en;
      logic       se_en;
      logic       mdr_en;
      logic       sht_en;
      logic       ir_en;
      logic       sgn_en;
      logic       spare;
   } ctrl_t;

   // Pass-through selectors as decoded by the companion ALU.
   localparam logic [3:0] ALU_ADD    = 4'b0100;
   localparam logic [3:0] ALU_SUB    = 4'b0010;
   localparam logic [3:0] ALU_PASS_A = 4'b1111;
   localparam logic [3:0] ALU_PASS_B = 4'b1101;

   state_t      state_q, state_d;
   ctrl_t       ctrl;
   logic        cond_pass;
   logic [1:0]  mem_size;
   logic        n_flag, z_flag, c_flag, v_flag;
   logic        unused_ir_bits;

   assign {n_flag, z_flag, c_flag, v_flag} = bus.Flags;
   assign mem_size       = bus.IR_In[22] ? 2'b00 : 2'b10;
   assign unused_ir_bits = ^bus.IR_In[19:0];

   always_ff @(posedge CLK) begin
      if (CLR) state_q <= ST_RST;
      else     state_q <= state_d;
   end

   always_comb begin
      cond_pass = 1'b0;
      case (bus.IR_In[31:28])
         4'b0000: cond_pass = z_flag;
         4'b0001: cond_pass = ~z_flag;
         4'b0010: cond_pass = c_flag;
         4'b0011: cond_pass = ~c_flag;
         4'b0100: cond_pass = n_flag;
         4'b0101: cond_pass = ~n_flag;
         4'b0110: cond_pass = v_flag;
         4'b0111: cond_pass = ~v_flag;
         4'b1000: cond_pass = c_flag & ~z_flag;
         4'b1001: cond_pass = ~c_flag | z_flag;
         4'b1010: cond_pass = (n_flag == v_flag);
         4'b1011: cond_pass = (n_flag != v_flag);
         4'b1100: cond_pass = ~z_flag & (n_flag == v_flag);
         4'b1101: cond_pass = z_flag | (n_flag != v_flag);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // MFC only matters in the three wait states; everywhere else it is ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RST:     state_d = ST_F_MAR;
         ST_F_MAR:   state_d = ST_F_PC;
         ST_F_PC:    state_d = ST_F_WAIT;
         ST_F_WAIT:  state_d = bus.MFC ? ST_F_IR : ST_F_WAIT;
         ST_F_IR:    state_d = ST_DECODE;
         ST_DECODE: begin
            if (!cond_pass)                     state_d = ST_F_MAR;
            else if (bus.IR_In[27:26] == 2'b00) state_d = ST_DP;
            else if (bus.IR_In[27:26] == 2'b01) state_d = ST_M_ADDR;
            else if (bus.IR_In[27:25] == 3'b101)
               state_d = bus.IR_In[24] ? ST_BL_LINK : ST_BR;
            else                                state_d = ST_F_MAR;
         end
         ST_DP:      state_d = ST_F_MAR;
         ST_BL_LINK: state_d = ST_BR;
         ST_BR:      state_d = ST_F_MAR;
         ST_M_ADDR:  state_d = bus.IR_In[20] ? ST_LD_WAIT : ST_ST_MDR;
         ST_LD_WAIT: state_d = bus.MFC ? ST_LD_WB : ST_LD_WAIT;
         ST_LD_WB:   state_d = ST_F_MAR;
         ST_ST_MDR:  state_d = ST_ST_WAIT;
         ST_ST_WAIT: state_d = bus.MFC ? ST_F_MAR : ST_ST_WAIT;
         default:    state_d = ST_RST;
      endcase
   end

   always_comb begin
      ctrl = '0;
      case (state_q)
         ST_RST: ctrl.rf_clr = 1'b1;
         ST_F_MAR: begin
            ctrl.sra    = 2'b01;
            ctrl.alua   = ALU_PASS_A;
            ctrl.mar_en = 1'b1;
         end
         ST_F_PC: begin
            ctrl.alua      = ALU_ADD;
            ctrl.salub     = 2'b01;
            ctrl.wra       = 2'b01;
            ctrl.rf_rw     = 1'b1;
            ctrl.mfa       = 1'b1;
            ctrl.rw_ram    = 1'b1;
            ctrl.data_size = 2'b10;
         end
         ST_F_WAIT: begin
            ctrl.mfa       = 1'b1;
            ctrl.rw_ram    = 1'b1;
            ctrl.data_size = 2'b10;
            ctrl.sma       = 1'b1;
            ctrl.mdr_en    = 1'b1;
            ctrl.sgn_en    = 1'b1;
         end
         ST_F_IR: ctrl.ir_en = 1'b1;
         // Compare-class opcodes (10xx) only update flags, never Rd.
         ST_DP: begin
            ctrl.salu   = 1'b1;
            ctrl.ssop   = ~bus.IR_In[25];
            ctrl.ssab   = 1'b1;
            ctrl.sht_en = 1'b1;
            ctrl.rf_rw  = (bus.IR_In[24:23] != 2'b10);
            ctrl.sr_en  = bus.IR_In[20];
         end
         ST_BL_LINK: begin
            ctrl.sra   = 2'b01;
            ctrl.wra   = 2'b10;
            ctrl.rf_rw = 1'b1;
            ctrl.alua  = ALU_PASS_A;
         end
         ST_BR: begin
            ctrl.sra   = 2'b01;
            ctrl.salub = 2'b10;
            ctrl.alua  = ALU_ADD;
            ctrl.wra   = 2'b01;
            ctrl.rf_rw = 1'b1;
         end
         ST_M_ADDR: begin
            ctrl.alua      = bus.IR_In[23] ? ALU_ADD : ALU_SUB;
            ctrl.mar_en    = 1'b1;
            ctrl.data_size = mem_size;
         end
         ST_LD_WAIT: begin
            ctrl.mfa       = 1'b1;
            ctrl.rw_ram    = 1'b1;
            ctrl.sma       = 1'b1;
            ctrl.mdr_en    = 1'b1;
            ctrl.sgn_en    = 1'b1;
            ctrl.data_size = mem_size;
         end
         ST_LD_WB: begin
            ctrl.alua      = ALU_PASS_B;
            ctrl.rf_rw     = 1'b1;
            ctrl.data_size = mem_size;
         end
         ST_ST_MDR: begin
            ctrl.srb       = 2'b10;
            ctrl.salub     = 2'b11;
            ctrl.alua      = ALU_PASS_B;
            ctrl.mdr_en    = 1'b1;
            ctrl.data_size = mem_size;
         end
         ST_ST_WAIT: begin
            ctrl.mfa       = 1'b1;
            ctrl.data_size = mem_size;
         end
         default: ctrl = '0;
      endcase
   end

   assign bus.Ctrl  = ctrl;
   assign bus.State = state_q;

endmodule

// File: tb/tb_arm_control_fsm.sv
// Randomised bench for arm_control_fsm, compared cycle by cycle against a
// state-number/field-table reference model of the control unit.
module tb_arm_control_fsm;

   localparam int P_MFA = 32, P_RW = 31, P_SALU = 30, P_DS = 28, P_RFCLR = 27;
   localparam int P_RFRW = 26, P_WRA = 24, P_SRA = 22, P_SRB = 20, P_SALUB = 16;
   localparam int P_ALUA = 12, P_SSAB = 11, P_SSOP = 10, P_SMA = 9, P_MAREN = 7;
   localparam int P_SREN = 6, P_MDREN = 4, P_SHTEN = 3, P_IREN = 2, P_SGNEN = 1;
   localparam logic [32:0] ADD = 33'd4, SUB = 33'd2, PASS_A = 33'd15, PASS_B = 33'd13;

   logic clk;
   logic clr;
   arm_control_fsm_if bus ();

   arm_control_fsm dut (
      .CLK (clk),
      .CLR (clr),
      .bus (bus)
   );

   int vector_count = 0;
   int miss_count   = 0;
   int ref_state    = 0;
   int wait_cnt     = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit cond_ok(logic [3:0] cond, logic [3:0] f);
      bit n, z, c, v, r;
      {n, z, c, v} = f;
      case (cond[3:1])
         3'd0: r = z;
         3'd1: r = c;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = c && !z;
         3'd5: r = (n == v);
         3'd6: r = !z && (n == v);
         default: return (cond[0] == 1'b0);
      endcase
      return cond[0] ? !r : r;
   endfunction

   function automatic int ref_next(int s, bit mfc, logic [3:0] f, logic [31:0] ir);
      case (s)
         0: return 1;
         1: return 2;
         2: return 3;
         3: return mfc ? 4 : 3;
         4: return 5;
         5: begin
            if (!cond_ok(ir[31:28], f)) return 1;
            if (ir[27:26] == 2'b00)      return 6;
            if (ir[27:26] == 2'b01)      return 9;
            if (ir[27:25] == 3'b101)     return ir[24] ? 7 : 8;
            return 1;
         end
         6: return 1;
         7: return 8;
         8: return 1;
         9: return ir[20] ? 10 : 12;
         10: return mfc ? 11 : 10;
         11: return 1;
         12: return 13;
         13: return mfc ? 1 : 13;
         default: return 0;
      endcase
   endfunction

   function automatic logic [32:0] ref_ctrl(int s, logic [31:0] ir);
      logic [32:0] c;
      logic [32:0] ds;
      c  = '0;
      ds = ir[22] ? 33'd0 : 33'd2;
      case (s)
         0: c |= 33'd1 << P_RFCLR;
         1: c |= (33'd1 << P_SRA) | (PASS_A << P_ALUA) | (33'd1 << P_MAREN);
         2: c |= (ADD << P_ALUA) | (33'd1 << P_SALUB) | (33'd1 << P_WRA) | (33'd1 << P_RFRW)
               | (33'd1 << P_MFA) | (33'd1 << P_RW) | (33'd2 << P_DS);
         3: c |= (33'd1 << P_MFA) | (33'd1 << P_RW) | (33'd2 << P_DS) | (33'd1 << P_SMA)
               | (33'd1 << P_MDREN) | (33'd1 << P_SGNEN);
         4: c |= 33'd1 << P_IREN;
         6: begin
            c |= (33'd1 << P_SALU) | (33'd1 << P_SSAB) | (33'd1 << P_SHTEN);
            if (!ir[25]) c |= 33'd1 << P_SSOP;
            if (ir[24:21] < 4'd8 || ir[24:21] > 4'd11) c |= 33'd1 << P_RFRW;
            if (ir[20]) c |= 33'd1 << P_SREN;
         end
         7: c |= (33'd1 << P_SRA) | (33'd2 << P_WRA) | (33'd1 << P_RFRW) | (PASS_A << P_ALUA);
         8: c |= (33'd1 << P_SRA) | (33'd2 << P_SALUB) | (ADD << P_ALUA) | (33'd1 << P_WRA)
               | (33'd1 << P_RFRW);
         9: c |= ((ir[23] ? ADD : SUB) << P_ALUA) | (33'd1 << P_MAREN) | (ds << P_DS);
         10: c |= (33'd1 << P_MFA) | (33'd1 << P_RW) | (33'd1 << P_SMA) | (33'd1 << P_MDREN)
                | (33'd1 << P_SGNEN) | (ds << P_DS);
         11: c |= (PASS_B << P_ALUA) | (33'd1 << P_RFRW) | (ds << P_DS);
         12: c |= (33'd2 << P_SRB) | (33'd3 << P_SALUB) | (PASS_B << P_ALUA)
                | (33'd1 << P_MDREN) | (ds << P_DS);
         13: c |= (33'd1 << P_MFA) | (ds << P_DS);
         default: c = '0;
      endcase
      return c;
   endfunction

   task automatic checkOutput(input string tag, input logic [32:0] observed,
                              input logic [32:0] expected);
      vector_count++;
      if (observed !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: observed %h, expected %h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // One clock: drive inputs after the falling edge, check the current state's
   // outputs, then advance the model with the inputs the next rising edge sees.
   task automatic applyStimulus(input bit c, input bit m, input logic [3:0] f,
                                input logic [31:0] ir);
      @(negedge clk);
      clr       = c;
      bus.MFC   = m;
      bus.Flags = f;
      bus.IR_In = ir;
      #1;
      checkOutput($sformatf("state@%0d", ref_state), {29'd0, bus.State}, 33'(ref_state));
      checkOutput($sformatf("ctrl@%0d", ref_state), bus.Ctrl, ref_ctrl(ref_state, ir));
      ref_state = c ? 0 : ref_next(ref_state, m, f, ir);
   endtask

   // Memory answers on the fourth cycle of any wait, with MFC low before that.
   task automatic stepProgram(input logic [31:0] ir, input logic [3:0] f);
      bit waiting;
      bit mfc;
      waiting = (ref_state == 3) || (ref_state == 10) || (ref_state == 13);
      if (!waiting) wait_cnt = 0;
      mfc = waiting && (wait_cnt == 3);
      if (waiting) wait_cnt++;
      applyStimulus(1'b0, mfc, f, ir);
   endtask

   task automatic runProgram(input logic [31:0] ir, input logic [3:0] f, input int cycles);
      for (int i = 0; i < cycles; i++) stepProgram(ir, f);
   endtask

   function automatic logic [31:0] random_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
         0: r[27:26] = 2'b00;
         1: r[27:26] = 2'b01;
         2: r[27:25] = 3'b101;
         default: r[27:26] = $urandom_range(0, 1) ? 2'b11 : 2'b10;
      endcase
      if ($urandom_range(0, 1) != 0) r[31:28] = 4'hE;
      return r;
   endfunction

   initial begin
      int budget;
      clr       = 1'b1;
      bus.MFC   = 1'b0;
      bus.Flags = 4'h0;
      bus.IR_In = 32'h0;

      applyStimulus(1'b1, 1'b0, 4'h0, 32'h0);
      applyStimulus(1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF);
      runProgram(32'hE281_1005, 4'b0000, 20);
      runProgram(32'hE151_0002, 4'b0000, 20);
      runProgram(32'h0A00_0010, 4'b0000, 16);
      runProgram(32'h0A00_0010, 4'b0100, 16);
      runProgram(32'hEB00_0001, 4'b0000, 20);
      runProgram(32'hE5D1_2000, 4'b0000, 24);
      runProgram(32'hE581_2000, 4'b0000, 24);
      runProgram(32'hF281_1005, 4'b1111, 12);

      budget = 0;
      while (ref_state != 10 && budget < 40) begin
         stepProgram(32'hE5D1_2000, 4'b0000);
         budget++;
      end
      if (ref_state != 10) begin
         miss_count++;
         $display("[TB] FAIL reach_ld_wait: model state %0d, expected 10", ref_state);
      end
      applyStimulus(1'b0, 1'b0, 4'h0, 32'hE5D1_2000);
      applyStimulus(1'b1, 1'b0, 4'h0, 32'hE5D1_2000);
      applyStimulus(1'b0, 1'b1, 4'h0, 32'hE5D1_2000);
      applyStimulus(1'b1, 1'b0, 4'h0, 32'hE5D1_2000);
      applyStimulus(1'b1, 1'b0, 4'h0, 32'hE5D1_2000);
      applyStimulus(1'b0, 1'b0, 4'h0, 32'hE5D1_2000);

      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(0, 99) < 2,
                       $urandom_range(0, 9) < 4,
                       4'($urandom),
                       random_instr());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
      $finish;
   end

endmodule
